cla_seq_ctrl: RTL and testbench

Multi-precision add sequencer for the shared 16-bit carry-lookahead adder. Accepts wide operands over a valid/ready request port, feeds them through the single external 16-bit adder one slice per cycle (LSB first), and chains the carry through a register. Returns the full-width sum, carry-out and signed overflow on a valid/ready response port. Sits between requesting datapath logic and the combinational adder instance, which it owns exclusively.

---
 rtl/cla_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_cla_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_ctrl.sv
// Multi-precision add sequencer: drives a shared combinational 16-bit adder one slice per cycle, LSB first.
// Latency: rsp_valid rises NUM_SLICES cycles after the accepting edge; next accept at earliest one cycle after the response handshake.
// Backpressure: req_ready only in IDLE; the result is held in DONE until rsp_ready, and no request is taken meanwhile.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_a, req_b (W bits), req_cin, req_sub
//   add_a, add_b, add_cin         slice presented to the external adder (zero outside RUN)
//   add_sum, add_cout             combinational adder result for the current slice
//   rsp_valid/rsp_ready           response handshake; rsp_sum (W bits), rsp_cout, rsp_ovf
//   busy                          high while an operation is in flight (RUN or DONE)
//
// Optional feature: define CLA_SEQ_SUB_EN to enable subtraction via req_sub
// (B inverted, initial carry forced to 1). Without it req_sub is ignored.

module cla_seq_ctrl #(
  parameter int NUM_SLICES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [16*NUM_SLICES-1:0]   req_a,
  input  logic [16*NUM_SLICES-1:0]   req_b,
  input  logic                       req_cin,
  input  logic                       req_sub,
  output logic [15:0]                add_a,
  output logic [15:0]                add_b,
  output logic                       add_cin,
  input  logic [15:0]                add_sum,
  input  logic                       add_cout,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [16*NUM_SLICES-1:0]   rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_ovf,
  output logic                       busy
);

  localparam int W = 16 * NUM_SLICES;
  // idx is 3 bits wide to cover the full 1..8 slice range.
  localparam logic [2:0] LAST_IDX = 3'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;     // holds B after optional inversion
  logic [W-1:0]   sum_reg;
  logic           carry;     // chained carry; after the top slice it is the final carry-out
  logic [2:0]     idx;

  logic [W-1:0]   b_in;
  logic           cin_in;
  logic [W-1:0]   a_shift;
  logic [W-1:0]   b_shift;

  // B is inverted once at accept time, so the stored b_reg is already the
  // effective operand seen by the adder and by the overflow check.
`ifdef CLA_SEQ_SUB_EN
  assign b_in   = req_sub ? ~req_b : req_b;
  assign cin_in = req_sub ? 1'b1 : req_cin;
`else
  logic unused_req_sub;
  assign unused_req_sub = req_sub;
  assign b_in   = req_b;
  assign cin_in = req_cin;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, partial-sum and carry registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      idx     <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_reg <= req_a;
            b_reg <= b_in;
            carry <= cin_in;
            idx   <= 3'd0;
          end
        end
        RUN: begin
          for (int i = 0; i < NUM_SLICES; i++) begin
            if (idx == 3'(i)) sum_reg[16*i +: 16] <= add_sum;
          end
          carry <= add_cout;
          idx   <= idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Current slice selection; shift by 16*idx keeps the select in range for any NUM_SLICES.
  assign a_shift = a_reg >> {idx, 4'b0000};
  assign b_shift = b_reg >> {idx, 4'b0000};

  always_comb begin
    add_a   = 16'd0;
    add_b   = 16'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_shift[15:0];
      add_b   = b_shift[15:0];
      add_cin = carry;
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign rsp_sum   = sum_reg;
  assign rsp_cout  = carry;
  // Signed overflow: operands share a sign that the result does not.
  assign rsp_ovf   = (a_reg[W-1] == b_reg[W-1]) && (sum_reg[W-1] != a_reg[W-1]);

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Self-checking bench for cla_seq_ctrl with a behavioural 16-bit adder.
// Table-driven vectors plus hand-written sequences for backpressure and mid-run reset.
// Summary line reports check and error counts.

module tb_cla_seq_ctrl;

  localparam int NS = 4;
  localparam int W  = 16 * NS;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          req_cin;
  logic          req_sub;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [15:0]   add_sum;
  logic          add_cout;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_sum;
  logic          rsp_cout;
  logic          rsp_ovf;
  logic          busy;

  int checks;
  int errors;
  logic cin_tr [0:31];

  cla_seq_ctrl #(.NUM_SLICES(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
    .busy(busy)
  );

  // External combinational adder
  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs [0:5];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from a negedge with req_ready high; returns at the
  // negedge where rsp_valid is seen (or the cycle budget expires).
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, output int lat);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    req_sub   = sub;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      cin_tr[lat] = add_cin;
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [W-1:0] held_sum;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = 1'b0;
    req_sub   = 1'b0;
    rsp_ready = 1'b0;

    vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};
`ifdef CLA_SEQ_SUB_EN
    vecs[5] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
`else
    vecs[5] = '{64'h5, 64'h7, 1'b0, 1'b1, 64'd12, 1'b0, 1'b0};
`endif

    // Reset state
    #12;
    chk("rst_req_ready", W'(req_ready), W'(1));
    chk("rst_rsp_valid", W'(rsp_valid), W'(0));
    chk("rst_rsp_sum",   rsp_sum, '0);
    chk("rst_rsp_cout",  W'(rsp_cout), W'(0));
    chk("rst_rsp_ovf",   W'(rsp_ovf), W'(0));
    chk("rst_busy",      W'(busy), W'(0));
    chk("rst_add_bus",   W'({add_a, add_b, add_cin}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("v%0d_req_ready", i), W'(req_ready), W'(1));
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
      chk($sformatf("v%0d_latency", i), W'(lat), W'(NS));
      chk($sformatf("v%0d_sum", i), rsp_sum, vecs[i].exp_sum);
      chk($sformatf("v%0d_cout", i), W'(rsp_cout), W'(vecs[i].exp_cout));
      chk($sformatf("v%0d_ovf", i), W'(rsp_ovf), W'(vecs[i].exp_ovf));
      if (i == 0) begin
        chk("v0_cin_slice0", W'(cin_tr[0]), W'(0));
        chk("v0_cin_slice1", W'(cin_tr[1]), W'(1));
      end
      finish_rsp();
    end

    // Backpressure in DONE: result held, no acceptance while req_valid toggles data
    run_op(64'h0000_0000_0000_0064, 64'h0000_0000_0000_00C8, 1'b0, 1'b0, lat);
    chk("hold_latency", W'(lat), W'(NS));
    held_sum = rsp_sum;
    chk("hold_sum0", held_sum, 64'h12C);
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      req_a = W'(c * 17 + 1000);
      @(negedge clk);
      chk($sformatf("hold%0d_valid", c), W'(rsp_valid), W'(1));
      chk($sformatf("hold%0d_sum", c), rsp_sum, held_sum);
      chk($sformatf("hold%0d_ready", c), W'(req_ready), W'(0));
      chk($sformatf("hold%0d_busy", c), W'(busy), W'(1));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("after_hs_ready", W'(req_ready), W'(1));
    chk("after_hs_valid", W'(rsp_valid), W'(0));
    run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
    chk("post_hold_latency", W'(lat), W'(NS));
    chk("post_hold_sum", rsp_sum, 64'd7);
    finish_rsp();

    // Reset after two RUN cycles aborts the operation
    req_valid = 1'b1;
    req_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    req_b     = 64'h1;
    req_cin   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_busy", W'(busy), W'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", W'(req_ready), W'(1));
    chk("abort_rsp_valid", W'(rsp_valid), W'(0));
    chk("abort_rsp_sum",   rsp_sum, '0);
    chk("abort_flags",     W'({rsp_cout, rsp_ovf, busy}), W'(0));
    chk("abort_add_bus",   W'({add_a, add_b, add_cin}), W'(0));
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", W'(rsp_valid), W'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_valid", W'(rsp_valid), W'(0));
    run_op(64'd3, 64'd4, 1'b0, 1'b0, lat);
    chk("post_rst_latency", W'(lat), W'(NS));
    chk("post_rst_sum", rsp_sum, 64'd7);
    chk("post_rst_cout", W'(rsp_cout), W'(0));
    finish_rsp();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
